// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the mips32 hazard/sequencing controller:
// mult/div FSM encoding, default unit latencies and the pipeline control width.
package hazard_ctrl_pkg;

    typedef enum logic {
        HC_IDLE = 1'b0,
        HC_BUSY = 1'b1
    } hc_state_t;

    localparam int DEF_MUL_LATENCY = 4;
    localparam int DEF_DIV_LATENCY = 32;

    // Width of the ID_EX control bundle; a flush zeroes all of it.
    localparam int CONTROL_SIZE = 16;

endpackage

// File: rtl/muldiv_timer.sv
// Occupancy timer for the multi-cycle mult/div unit: busy for exactly LAT
// cycles after a one-cycle start pulse.
module muldiv_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(DIV_LATENCY + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

    hc_state_t     r_state;
    hc_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HC_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // cnt holds the number of busy cycles still to come after the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        case (r_state)
            HC_IDLE: begin
                if (start) begin
                    w_state_nxt = HC_BUSY;
                    w_cnt_nxt   = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            HC_BUSY: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = HC_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = HC_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use and HI/LO stalls, taken-branch
// flushes, mult/div start sequencing and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_muldiv,
    input  logic        id_is_div,
    input  logic        id_hilo_read,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic [31:0] stall_count
);

    logic        w_busy;
    logic        w_load_use;
    logic        w_md_stall;
    logic        w_start;
    logic [31:0] r_stall_count;

    assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));
    assign w_md_stall = w_busy && (id_hilo_read || id_muldiv);
    assign w_start    = !rst && id_muldiv && !ex_branch_taken &&
                        !w_load_use && !w_md_stall;

    muldiv_timer #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .is_div (id_is_div),
        .busy   (w_busy)
    );

    // A taken branch outranks every stall: the ID instruction is wrong-path.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        muldiv_start = w_start;
        muldiv_busy  = w_busy;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            muldiv_start = 1'b0;
            muldiv_busy  = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use || w_md_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (!pc_write && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;

endmodule
